// File: rtl/universal_shift_reg_burst_if.sv
// Control/data bundle for the universal shift register with burst engine.
interface universal_shift_reg_burst_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic             s_left_din;
  logic             s_right_din;
  logic [WIDTH-1:0] parallel_din;
  logic             start;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] parallel_dout;
  logic             s_left_dout;
  logic             s_right_dout;
  logic             busy;
  logic             done;

  // Controller side: drives operations, observes register and burst status.
  modport master (
    output en, mode, s_left_din, s_right_din, parallel_din, start, shift_cnt,
    input  parallel_dout, s_left_dout, s_right_dout, busy, done
  );

  // Register side.
  modport slave (
    input  en, mode, s_left_din, s_right_din, parallel_din, start, shift_cnt,
    output parallel_dout, s_left_dout, s_right_dout, busy, done
  );
endinterface

// File: rtl/universal_shift_reg_burst.sv
// WIDTH-bit universal shift register with rotate/arithmetic modes, clock
// enable and a burst engine that repeats a shift mode for a programmed count.
module universal_shift_reg_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic                     clk,
  input logic                     rst,
  universal_shift_reg_burst_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic             done_q, done_d;

  function automatic logic is_shift(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100) ||
           (m == 3'b101) || (m == 3'b110);
  endfunction

  function automatic logic [WIDTH-1:0] step_val(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] q,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] pd
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (m)
      3'b001:  r = {sl, q[WIDTH-1:1]};
      3'b010:  r = {q[WIDTH-2:0], sr};
      3'b011:  r = pd;
      3'b100:  r = {q[0], q[WIDTH-1:1]};
      3'b101:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b110:  r = {q[WIDTH-1], q[WIDTH-1:1]};
      default: r = q;  // 000 hold, 111 reserved
    endcase
    return r;
  endfunction

  // State and datapath registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Next-state: enter BUSY only for multi-step bursts, leave on the last step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.en && bus.start && is_shift(bus.mode) && (bus.shift_cnt > CNT_W'(1))) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.en && (rem_q == CNT_W'(1))) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and burst bookkeeping; done is a one-cycle pulse by default-low.
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    mode_d = mode_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          if (bus.start && is_shift(bus.mode)) begin
            // First step of a burst happens on the start edge itself.
            if (bus.shift_cnt != '0) begin
              data_d = step_val(bus.mode, data_q, bus.s_left_din, bus.s_right_din,
                                bus.parallel_din);
            end
            if (bus.shift_cnt <= CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              mode_d = bus.mode;
              rem_d  = bus.shift_cnt - CNT_W'(1);
            end
          end else begin
            data_d = step_val(bus.mode, data_q, bus.s_left_din, bus.s_right_din,
                              bus.parallel_din);
          end
        end
      end
      StBusy: begin
        if (bus.en) begin
          data_d = step_val(mode_q, data_q, bus.s_left_din, bus.s_right_din,
                            bus.parallel_din);
          rem_d  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.parallel_dout = data_q;
  assign bus.s_left_dout   = data_q[WIDTH-1];
  assign bus.s_right_dout  = data_q[0];
  assign bus.busy          = (state_q == StBusy);
  assign bus.done          = done_q;

endmodule
